// File: rtl/sig_debounce_pkg.sv
// Shared definitions for the sig_debounce block: FSM encodings, default
// configuration values and a configuration legality helper.
package sig_debounce_pkg;

  // Default configuration: 4-bit stability counter, 8 stable cycles to accept.
  localparam int unsigned DEF_CNT_W         = 4;
  localparam int unsigned DEF_STABLE_CYCLES = 8;

  // Two-state debounce FSM. IDLE: input agrees with dout. COUNT: input
  // disagrees and is being timed.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } deb_state_e;

  // True when the stability count fits the counter without wrapping.
  // Counter widths are limited to 1..31 so the range math stays in 32 bits.
  function automatic bit cfg_legal(input int unsigned stable_cycles,
                                   input int unsigned cnt_w);
    int unsigned max_cnt;
    if (cnt_w < 1 || cnt_w > 31) begin
      return 1'b0;
    end
    max_cnt = (32'd1 << cnt_w) - 32'd1;
    return (stable_cycles >= 1) && (stable_cycles <= max_cnt);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level. Both flops clear to 0 on the
// asynchronous active-low reset. Used by sig_debounce when DEBOUNCE_SYNC_EN
// is defined.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/sig_debounce.sv
// Debouncer for a single-bit level: dout follows the sampled input only after
// it has differed from dout for STABLE_CYCLES consecutive enabled edges.
// Emits one-cycle rise/fall pulses when dout flips; busy marks a count in
// progress.
// Build option: define DEBOUNCE_SYNC_EN to sample din through a 2-flop
// synchronizer (asynchronous din). Undefined: one register on din, for
// clk-domain sources only.
module sig_debounce
  import sig_debounce_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Refuse to build a counter that could wrap before reaching the target.
  if (!cfg_legal(STABLE_CYCLES, CNT_W)) begin : g_bad_cfg
    $error("sig_debounce: STABLE_CYCLES must be in 1..2**CNT_W-1");
  end

  // Count value held on the edge that accepts the new level.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  deb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

`ifdef DEBOUNCE_SYNC_EN
  // Asynchronous din: FSM sees din two edges after it changes.
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s)
  );
`else
  // Same-domain din: a single sampling register is enough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s <= 1'b0;
    end else begin
      s <= din;
    end
  end
`endif

  // Debounce FSM, stability counter and registered outputs. en=0 freezes
  // everything except the pulses, which always clear after one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (en) begin
        unique case (state_q)
          ST_IDLE: begin
            if (s != dout) begin
              if (STABLE_CYCLES == 1) begin
                // Single-cycle stability: accept on the first disagreeing edge.
                dout  <= s;
                rise  <= s;
                fall  <= ~s;
                cnt_q <= '0;
              end else begin
                state_q <= ST_COUNT;
                cnt_q   <= CNT_W'(1);
                busy    <= 1'b1;
              end
            end else begin
              cnt_q <= '0;
            end
          end
          ST_COUNT: begin
            if (s == dout) begin
              // Input bounced back before the count finished: drop it quietly.
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              busy    <= 1'b0;
            end else if (cnt_q == LAST_CNT) begin
              dout    <= s;
              rise    <= s;
              fall    <= ~s;
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              busy    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
